// File: rtl/wb_ram_slave_if.sv
// Wishbone B3 slave-side bus bundle for wb_ram_slave (classic + registered-feedback burst).
// Signal names follow the slave's point of view (_i into the RAM, _o out of it).
interface wb_ram_slave_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone B3 single-port 32-bit RAM slave with zero-wait-state incrementing/wrap bursts.
// Optional WB_RAM_SLAVE_ERR_EN: out-of-range addresses answer with wb_err_o instead of wb_ack_o.
module wb_ram_slave #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_ni,
    wb_ram_slave_if.slave  wb
);
    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [2:0] CTI_INCR = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   addr_q;
    logic [31:0]     mem [DEPTH];

    logic            req;
    logic            oor;
    logic            wr_en;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   nxt_addr;

    // Next burst address: only the wrap-window bits advance, upper bits are kept.
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a, input logic [1:0] bte);
        logic [AW-1:0] inc;
        inc = a + AW'(1);
        case (bte)
            2'b01:   nxt = {a[AW-1:2], inc[1:0]};
            2'b10:   nxt = {a[AW-1:3], inc[2:0]};
            2'b11:   nxt = {a[AW-1:4], inc[3:0]};
            default: nxt = inc;
        endcase
    endfunction

    assign req      = wb.wb_cyc_i & wb.wb_stb_i;
    assign idx      = wb.wb_adr_i[AW+1:2];
    assign nxt_addr = nxt(addr_q, wb.wb_bte_i);

`ifdef WB_RAM_SLAVE_ERR_EN
    assign oor = |wb.wb_adr_i[31:AW+2];
    logic unused_adr;
    assign unused_adr = ^wb.wb_adr_i[1:0];
`else
    assign oor = 1'b0;
    logic unused_adr;
    assign unused_adr = ^{wb.wb_adr_i[31:AW+2], wb.wb_adr_i[1:0]};
`endif

    // The ACK state is the classic turnaround cycle, so a still-held request must not write twice.
    assign wr_en = wb_rst_ni & req & wb.wb_we_i & ~oor & (state != ACK);

    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wb.wb_sel_i[b]) begin
                    mem[idx][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            addr_q      <= '0;
            wb.wb_ack_o <= 1'b0;
            wb.wb_err_o <= 1'b0;
            wb.wb_dat_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (oor) begin
                            wb.wb_err_o <= 1'b1;
                            wb.wb_dat_o <= '0;
                            state       <= ACK;
                        end else begin
                            wb.wb_ack_o <= 1'b1;
                            addr_q      <= idx;
                            wb.wb_dat_o <= mem[idx];
                            state       <= (wb.wb_cti_i == CTI_INCR) ? BURST : ACK;
                        end
                    end
                end
                ACK: begin
                    wb.wb_ack_o <= 1'b0;
                    wb.wb_err_o <= 1'b0;
                    state       <= IDLE;
                end
                BURST: begin
                    if (!req) begin
                        wb.wb_ack_o <= 1'b0;
                        state       <= IDLE;
                    end else if (oor) begin
                        wb.wb_ack_o <= 1'b0;
                        wb.wb_err_o <= 1'b1;
                        wb.wb_dat_o <= '0;
                        state       <= ACK;
                    end else if (wb.wb_cti_i == CTI_INCR) begin
                        // Prefetch the predicted next beat so its data is ready with the ack.
                        addr_q      <= nxt_addr;
                        wb.wb_dat_o <= mem[nxt_addr];
                    end else begin
                        wb.wb_ack_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    wb.wb_ack_o <= 1'b0;
                    wb.wb_err_o <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign wb.wb_rty_o = 1'b0;
endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: classic, linear/wrap bursts, master wait state, reset mid-burst.
// Honours WB_RAM_SLAVE_ERR_EN for the out-of-range access case.
module tb_wb_ram_slave;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] b_adr [4];
    logic [31:0] b_dat [4];

    wb_ram_slave_if bus ();

    wb_ram_slave #(.DEPTH(1024)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wb        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cyc, input logic stb, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] cti,
                         input logic [1:0] bte);
        bus.wb_cyc_i = cyc;
        bus.wb_stb_i = stb;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        bus.wb_cti_i = cti;
        bus.wb_bte_i = bte;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
    endtask

    // Classic cycle: request held through the ack cycle, dropped once ack has been seen.
    task automatic classic_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                                 input string tag);
        drive(1'b1, 1'b1, 1'b1, adr, dat, sel, 3'b000, 2'b00);
        check({tag, ".ack_n"}, 32'(bus.wb_ack_o), 32'h0);
        step();
        check({tag, ".ack_n1"}, 32'(bus.wb_ack_o), 32'h1);
        step();
        idle();
        check({tag, ".ack_n2"}, 32'(bus.wb_ack_o), 32'h0);
    endtask

    task automatic classic_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
        drive(1'b1, 1'b1, 1'b0, adr, 32'h0, 4'hf, 3'b000, 2'b00);
        step();
        check({tag, ".ack"}, 32'(bus.wb_ack_o), 32'h1);
        check({tag, ".dat"}, bus.wb_dat_o, exp);
        step();
        idle();
        check({tag, ".ack_low"}, 32'(bus.wb_ack_o), 32'h0);
    endtask

    // 4-beat registered-feedback burst using b_adr / b_dat (write data or expected read data).
    task automatic burst(input logic we, input logic [1:0] bte, input string tag);
        drive(1'b1, 1'b1, we, b_adr[0], b_dat[0], 4'hf, 3'b010, bte);
        for (int k = 0; k < 4; k++) begin
            step();
            drive(1'b1, 1'b1, we, b_adr[k], b_dat[k], 4'hf, (k == 3) ? 3'b111 : 3'b010, bte);
            check($sformatf("%s.ack%0d", tag, k), 32'(bus.wb_ack_o), 32'h1);
            if (!we) check($sformatf("%s.dat%0d", tag, k), bus.wb_dat_o, b_dat[k]);
        end
        step();
        idle();
        check({tag, ".ack_end"}, 32'(bus.wb_ack_o), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) step();
        check("rst.ack", 32'(bus.wb_ack_o), 32'h0);
        check("rst.err", 32'(bus.wb_err_o), 32'h0);
        check("rst.dat", bus.wb_dat_o, 32'h0);
        check("rst.rty", 32'(bus.wb_rty_o), 32'h0);
        rst_n = 1'b1;
        step();

        // Byte-lane merge on a classic write.
        classic_write(32'h10, 32'hDEADBEEF, 4'b1111, "cw0");
        classic_write(32'h10, 32'h00000011, 4'b0001, "cw1");
        classic_read(32'h10, 32'hDEADBE11, "cr0");

        // Linear read burst over words 4..7.
        for (int i = 0; i < 4; i++) classic_write(32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 4'hf, "pre_lin");
        for (int i = 0; i < 4; i++) begin
            b_adr[i] = 32'h10 + 32'(4 * i);
            b_dat[i] = 32'hA0 + 32'(i);
        end
        burst(1'b0, 2'b00, "lin");

        // Wrap4 read burst starting at word 2.
        for (int i = 0; i < 4; i++) classic_write(32'(4 * i), 32'(i), 4'hf, "pre_wrap");
        b_adr[0] = 32'h8;  b_dat[0] = 32'd2;
        b_adr[1] = 32'hC;  b_dat[1] = 32'd3;
        b_adr[2] = 32'h0;  b_dat[2] = 32'd0;
        b_adr[3] = 32'h4;  b_dat[3] = 32'd1;
        burst(1'b0, 2'b01, "wrap4");

        // Linear write burst with a one-cycle master wait state after beat 2.
        drive(1'b1, 1'b1, 1'b1, 32'h40, 32'h40404000, 4'hf, 3'b010, 2'b00);
        step();
        check("ws.ack_b0", 32'(bus.wb_ack_o), 32'h1);
        step();
        drive(1'b1, 1'b1, 1'b1, 32'h44, 32'h40404001, 4'hf, 3'b010, 2'b00);
        check("ws.ack_b1", 32'(bus.wb_ack_o), 32'h1);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h48, 32'h40404002, 4'hf, 3'b010, 2'b00);
        step();
        check("ws.ack_drop", 32'(bus.wb_ack_o), 32'h0);
        drive(1'b1, 1'b1, 1'b1, 32'h48, 32'h40404002, 4'hf, 3'b010, 2'b00);
        step();
        check("ws.ack_b2", 32'(bus.wb_ack_o), 32'h1);
        step();
        drive(1'b1, 1'b1, 1'b1, 32'h4C, 32'h40404003, 4'hf, 3'b111, 2'b00);
        check("ws.ack_b3", 32'(bus.wb_ack_o), 32'h1);
        step();
        idle();
        check("ws.ack_end", 32'(bus.wb_ack_o), 32'h0);
        for (int i = 0; i < 4; i++)
            classic_read(32'h40 + 32'(4 * i), 32'h40404000 + 32'(i), $sformatf("ws.rd%0d", i));

        // Reset asserted during beat 2 of a write burst.
        classic_write(32'h84, 32'h33333333, 4'hf, "pre_rst");
        drive(1'b1, 1'b1, 1'b1, 32'h80, 32'hC0DE0000, 4'hf, 3'b010, 2'b00);
        step();
        check("rb.ack_b0", 32'(bus.wb_ack_o), 32'h1);
        step();
        drive(1'b1, 1'b1, 1'b1, 32'h84, 32'hC0DE0001, 4'hf, 3'b010, 2'b00);
        rst_n = 1'b0;
        step();
        check("rb.ack", 32'(bus.wb_ack_o), 32'h0);
        check("rb.err", 32'(bus.wb_err_o), 32'h0);
        check("rb.dat", bus.wb_dat_o, 32'h0);
        rst_n = 1'b1;
        idle();
        step();
        classic_read(32'h80, 32'hC0DE0000, "rb.kept");
        classic_read(32'h84, 32'h33333333, "rb.unchanged");

`ifdef WB_RAM_SLAVE_ERR_EN
        drive(1'b1, 1'b1, 1'b1, 32'h00001000, 32'h12345678, 4'hf, 3'b000, 2'b00);
        step();
        check("oor.err", 32'(bus.wb_err_o), 32'h1);
        check("oor.ack", 32'(bus.wb_ack_o), 32'h0);
        step();
        idle();
        check("oor.err_low", 32'(bus.wb_err_o), 32'h0);
        check("oor.ack_low", 32'(bus.wb_ack_o), 32'h0);
        classic_read(32'h0, 32'h0, "oor.word0");
`else
        classic_write(32'h00001000, 32'h12345678, 4'hf, "alias");
        classic_read(32'h0, 32'h12345678, "alias.word0");
`endif

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
